// File: rtl/piso_tx_sched.sv
// Two-requester round-robin transmit scheduler feeding one LSB-first PISO lane.
// A word is loaded on the IDLE handshake, shifted out over WIDTH cycles, then padded by GAP idle cycles.
module piso_tx_sched #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sdout,
    output logic             sframe,
    output logic             sowner,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    localparam logic [5:0] LAST_BIT = 6'(WIDTH - 1);
    localparam logic [5:0] LAST_GAP = (GAP > 0) ? 6'(GAP - 1) : 6'd0;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [5:0]       r_cnt;
    logic             r_lastGrant;
    logic             r_sframe;
    logic             r_sowner;
    logic             r_busy;
    logic             r_done;

    logic             w_idle;
    logic             w_grant0;
    logic             w_grant1;

    // A tie goes to whichever requester was not served last.
    assign w_idle   = (r_state == S_IDLE) && !reset;
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_lastGrant);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_lastGrant);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // The register zero-fills, so its LSB is already 0 outside a frame.
    assign sdout  = r_sframe & r_shreg[0];
    assign sframe = r_sframe;
    assign sowner = r_sowner;
    assign busy   = r_busy;
    assign done   = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_lastGrant <= 1'b1;
            r_sframe    <= 1'b0;
            r_sowner    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_shreg     <= w_grant0 ? req0_data : req1_data;
                        r_cnt       <= '0;
                        r_sowner    <= w_grant1;
                        r_lastGrant <= w_grant1;
                        r_sframe    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shreg <= r_shreg >> 1;
                    if (r_cnt == LAST_BIT) begin
                        r_cnt    <= '0;
                        r_sframe <= 1'b0;
                        r_done   <= 1'b0;
                        if (GAP > 0) begin
                            r_state <= S_GAP;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt  <= r_cnt + 6'd1;
                        r_done <= ((r_cnt + 6'd1) == LAST_BIT);
                    end
                end
                S_GAP: begin
                    if (r_cnt == LAST_GAP) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx_sched.sv
// Self-checking bench for piso_tx_sched: one instance with GAP=0 (unit 0) and one with GAP=3 (unit 1),
// compared every cycle against a frame-schedule reference model plus scenario-specific checks.
module tb_piso_tx_sched;

    localparam int W    = 8;
    localparam int GAP1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [1:0]   v0, v1;
    logic [W-1:0] d0 [2];
    logic [W-1:0] d1 [2];
    logic [1:0]   r0O, r1O, sdoutO, sframeO, sownerO, busyO, doneO;

    piso_tx_sched #(.WIDTH(W), .GAP(0)) dut0 (
        .clk(clk), .reset(reset),
        .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(r0O[0]),
        .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(r1O[0]),
        .sdout(sdoutO[0]), .sframe(sframeO[0]), .sowner(sownerO[0]),
        .busy(busyO[0]), .done(doneO[0])
    );

    piso_tx_sched #(.WIDTH(W), .GAP(GAP1)) dut1 (
        .clk(clk), .reset(reset),
        .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(r0O[1]),
        .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(r1O[1]),
        .sdout(sdoutO[1]), .sframe(sframeO[1]), .sowner(sownerO[1]),
        .busy(busyO[1]), .done(doneO[1])
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: a frame is remembered only by its transfer cycle, word and owner;
    // every output is derived from the distance to that transfer cycle.
    int           frameT [2];
    logic [W-1:0] frameD [2];
    logic         ownerM [2];
    int           freeAt [2];
    logic         lastG  [2];
    logic         g0     [2];
    logic         g1     [2];
    logic [6:0]   expV   [2];

    function automatic int gapOf(input int u);
        return (u == 0) ? 0 : GAP1;
    endfunction

    function automatic logic [6:0] obsVec(input int u);
        return {sdoutO[u], sframeO[u], sownerO[u], busyO[u], doneO[u], r0O[u], r1O[u]};
    endfunction

    task automatic computeExpected(input int u);
        int k;
        logic [W-1:0] fd;
        logic sd, sf, bz, dn;
        sd = 1'b0; sf = 1'b0; bz = 1'b0; dn = 1'b0;
        fd = frameD[u];
        k = cyc - frameT[u] - 1;
        if (frameT[u] >= 0 && k >= 0 && k < W) begin
            sf = 1'b1;
            sd = fd[k];
            dn = (k == W - 1);
            bz = 1'b1;
        end else if (frameT[u] >= 0 && k >= W && k < W + gapOf(u)) begin
            bz = 1'b1;
        end
        g0[u] = 1'b0;
        g1[u] = 1'b0;
        if (!reset && cyc >= freeAt[u]) begin
            if (v0[u] && v1[u]) begin
                g0[u] = lastG[u];
                g1[u] = !lastG[u];
            end else begin
                g0[u] = v0[u];
                g1[u] = v1[u];
            end
        end
        expV[u] = {sd, sf, ownerM[u], bz, dn, g0[u], g1[u]};
    endtask

    task automatic commitModel(input int u);
        if (reset) begin
            frameT[u] = -1000;
            ownerM[u] = 1'b0;
            freeAt[u] = cyc + 1;
            lastG[u]  = 1'b1;
        end else if (g0[u] || g1[u]) begin
            frameT[u] = cyc;
            frameD[u] = g0[u] ? d0[u] : d1[u];
            ownerM[u] = g1[u];
            lastG[u]  = g1[u];
            freeAt[u] = cyc + W + 1 + gapOf(u);
        end
    endtask

    // Inputs change right after the falling edge; everything is sampled 1 ns later.
    task automatic beginCycle();
        @(negedge clk);
    endtask

    task automatic sampleCycle();
        #1;
        computeExpected(0);
        computeExpected(1);
    endtask

    task automatic finishCycle();
        commitModel(0);
        commitModel(1);
        cyc++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            beginCycle();
            reset = 1'b1;
            sampleCycle();
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obsVec(u) !== expV[u]) begin
                    errors++;
                    $display("[TB] FAIL reset_model u=%0d cyc=%0d got=%b exp=%b", u, cyc, obsVec(u), expV[u]);
                end
                checks++;
                if (obsVec(u) !== 7'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_values u=%0d cyc=%0d got=%b exp=0000000", u, cyc, obsVec(u));
                end
            end
            finishCycle();
        end
    endtask

    task automatic test_single();
        int rdyC, doneC, firstC, nb, nDone;
        logic [W-1:0] col;
        rdyC = -1; doneC = -1; firstC = -1; nb = 0; nDone = 0; col = '0;
        for (int i = 0; i < 16; i++) begin
            beginCycle();
            reset = 1'b0;
            v1[0] = 1'b0;
            if (g0[0]) v0[0] = 1'b0;
            else if (i == 2) begin
                v0[0] = 1'b1;
                d0[0] = 8'hA5;
            end
            sampleCycle();
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obsVec(u) !== expV[u]) begin
                    errors++;
                    $display("[TB] FAIL single_model u=%0d cyc=%0d got=%b exp=%b", u, cyc, obsVec(u), expV[u]);
                end
            end
            if (r0O[0]) rdyC = cyc;
            if (sframeO[0]) begin
                if (firstC < 0) firstC = cyc;
                if (nb < W) col[nb] = sdoutO[0];
                nb++;
            end
            if (doneO[0]) begin
                doneC = cyc;
                nDone++;
            end
            finishCycle();
        end
        checks++;
        if (col !== 8'hA5 || nb != W) begin
            errors++;
            $display("[TB] FAIL single_bits got=%h/%0d bits exp=a5/8 bits", col, nb);
        end
        checks++;
        if (rdyC < 0 || firstC != rdyC + 1 || doneC != rdyC + W || nDone != 1) begin
            errors++;
            $display("[TB] FAIL single_timing ready=%0d first=%0d done=%0d x%0d exp first=ready+1 done=ready+%0d x1",
                     rdyC, firstC, doneC, nDone, W);
        end
    endtask

    task automatic test_tie_alternate();
        int seqG[$];
        int seqC[$];
        int overlap;
        int expSeq [4];
        expSeq = '{0, 1, 0, 1};
        overlap = 0;
        for (int i = 0; i < 42; i++) begin
            beginCycle();
            reset = (i == 0);
            v0[0] = (i != 0);
            v1[0] = (i != 0);
            d0[0] = 8'h0F;
            d1[0] = 8'hF0;
            sampleCycle();
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obsVec(u) !== expV[u]) begin
                    errors++;
                    $display("[TB] FAIL tie_model u=%0d cyc=%0d got=%b exp=%b", u, cyc, obsVec(u), expV[u]);
                end
            end
            if (r0O[0] && r1O[0]) overlap++;
            else if (r0O[0] || r1O[0]) begin
                seqG.push_back(r1O[0] ? 1 : 0);
                seqC.push_back(cyc);
            end
            finishCycle();
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("[TB] FAIL tie_overlap got=%0d exp=0", overlap);
        end
        checks++;
        if (seqG.size() < 4) begin
            errors++;
            $display("[TB] FAIL tie_count got=%0d grants exp>=4", seqG.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (seqG[j] != expSeq[j]) begin
                    errors++;
                    $display("[TB] FAIL tie_order idx=%0d got=%0d exp=%0d", j, seqG[j], expSeq[j]);
                end
            end
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (seqC[j+1] - seqC[j] != W + 1) begin
                    errors++;
                    $display("[TB] FAIL tie_spacing idx=%0d got=%0d exp=%0d", j, seqC[j+1] - seqC[j], W + 1);
                end
            end
        end
    endtask

    task automatic test_gap();
        int n, lowCnt;
        int rc[$];
        logic sf [40];
        n = 0;
        for (int i = 0; i < 40; i++) begin
            beginCycle();
            reset = 1'b0;
            v0[1] = 1'b0;
            if (g1[1]) begin
                n++;
                if (n == 1) d1[1] = W'($urandom);
                else v1[1] = 1'b0;
            end else if (i == 1) begin
                v1[1] = 1'b1;
                d1[1] = W'($urandom);
            end
            sampleCycle();
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obsVec(u) !== expV[u]) begin
                    errors++;
                    $display("[TB] FAIL gap_model u=%0d cyc=%0d got=%b exp=%b", u, cyc, obsVec(u), expV[u]);
                end
            end
            sf[i] = sframeO[1];
            if (r1O[1]) rc.push_back(i);
            finishCycle();
        end
        checks++;
        if (rc.size() != 2) begin
            errors++;
            $display("[TB] FAIL gap_grants got=%0d exp=2", rc.size());
        end else begin
            checks++;
            if (rc[1] - rc[0] != W + 1 + GAP1) begin
                errors++;
                $display("[TB] FAIL gap_spacing got=%0d exp=%0d", rc[1] - rc[0], W + 1 + GAP1);
            end
            lowCnt = 0;
            for (int j = rc[0] + W + 1; j <= rc[1] && j < 40; j++) if (!sf[j]) lowCnt++;
            checks++;
            if (lowCnt != GAP1 + 1) begin
                errors++;
                $display("[TB] FAIL gap_sframe_low got=%0d exp=%0d", lowCnt, GAP1 + 1);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int t, nDone, firstGrant;
        bit tiePhase;
        t = -1; nDone = 0; firstGrant = -1; tiePhase = 0;
        for (int i = 0; i < 24; i++) begin
            beginCycle();
            reset = 1'b0;
            if (tiePhase && (g0[0] || g1[0])) begin
                v0[0] = 1'b0;
                v1[0] = 1'b0;
            end else if (t < 0 && g0[0]) begin
                t = cyc - 1;
                v0[0] = 1'b0;
            end else if (i == 0) begin
                v0[0] = 1'b1;
                v1[0] = 1'b0;
                d0[0] = W'($urandom);
            end
            if (t >= 0 && cyc == t + 4) reset = 1'b1;
            if (t >= 0 && cyc == t + 7) begin
                tiePhase = 1;
                v0[0] = 1'b1;
                v1[0] = 1'b1;
                d0[0] = W'($urandom);
                d1[0] = W'($urandom);
            end
            sampleCycle();
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obsVec(u) !== expV[u]) begin
                    errors++;
                    $display("[TB] FAIL abort_model u=%0d cyc=%0d got=%b exp=%b", u, cyc, obsVec(u), expV[u]);
                end
            end
            if (t >= 0 && !tiePhase && doneO[0]) nDone++;
            if (t >= 0 && cyc == t + 5) begin
                checks++;
                if ({sframeO[0], busyO[0], doneO[0]} !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL abort_outputs got=%b exp=000", {sframeO[0], busyO[0], doneO[0]});
                end
            end
            if (tiePhase && firstGrant < 0 && (r0O[0] || r1O[0])) firstGrant = r1O[0] ? 1 : 0;
            finishCycle();
        end
        checks++;
        if (nDone != 0) begin
            errors++;
            $display("[TB] FAIL abort_done got=%0d pulses exp=0", nDone);
        end
        checks++;
        if (firstGrant != 0) begin
            errors++;
            $display("[TB] FAIL abort_pointer got=%0d exp=0", firstGrant);
        end
    endtask

    task automatic test_late();
        int rc1, rc0, nb, rdyBusy;
        logic [W-1:0] dLate, col;
        rc1 = -1; rc0 = -1; nb = 0; rdyBusy = 0; col = '0;
        dLate = W'($urandom);
        for (int i = 0; i < 34; i++) begin
            beginCycle();
            reset = 1'b0;
            if (i == 0) begin
                v0[0] = 1'b0;
                v1[0] = 1'b1;
                d1[0] = W'($urandom);
            end
            if (g1[0]) v1[0] = 1'b0;
            if (g0[0]) v0[0] = 1'b0;
            if (rc1 >= 0 && cyc == rc1 + 3) begin
                v0[0] = 1'b1;
                d0[0] = dLate;
            end
            sampleCycle();
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obsVec(u) !== expV[u]) begin
                    errors++;
                    $display("[TB] FAIL late_model u=%0d cyc=%0d got=%b exp=%b", u, cyc, obsVec(u), expV[u]);
                end
            end
            if (r1O[0] && rc1 < 0) rc1 = cyc;
            if (r0O[0] && busyO[0]) rdyBusy++;
            if (r0O[0] && rc0 < 0) rc0 = cyc;
            if (rc0 >= 0 && cyc > rc0 && sframeO[0]) begin
                if (nb < W) col[nb] = sdoutO[0];
                nb++;
            end
            finishCycle();
        end
        checks++;
        if (rdyBusy != 0) begin
            errors++;
            $display("[TB] FAIL late_ready_busy got=%0d exp=0", rdyBusy);
        end
        checks++;
        if (rc1 < 0 || rc0 != rc1 + W + 1) begin
            errors++;
            $display("[TB] FAIL late_grant got=%0d exp=%0d", rc0, rc1 + W + 1);
        end
        checks++;
        if (col !== dLate || nb != W) begin
            errors++;
            $display("[TB] FAIL late_data got=%h/%0d bits exp=%h/%0d bits", col, nb, dLate, W);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 32; i++) begin
            beginCycle();
            reset = 1'b0;
            v0 = 2'b00;
            v1 = 2'b00;
            sampleCycle();
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obsVec(u) !== expV[u]) begin
                    errors++;
                    $display("[TB] FAIL idle_model u=%0d cyc=%0d got=%b exp=%b", u, cyc, obsVec(u), expV[u]);
                end
            end
            if (i >= 12) begin
                checks++;
                if ({sframeO[0], busyO[0], doneO[0], r0O[0], r1O[0]} !== 5'b0) begin
                    errors++;
                    $display("[TB] FAIL idle_quiet cyc=%0d got=%b exp=00000", cyc,
                             {sframeO[0], busyO[0], doneO[0], r0O[0], r1O[0]});
                end
            end
            finishCycle();
        end
    endtask

    // Random traffic on both units: words are held until accepted, resets are rare.
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            beginCycle();
            reset = ($urandom_range(0, 79) == 0);
            for (int u = 0; u < 2; u++) begin
                if (g0[u]) begin
                    v0[u] = ($urandom_range(0, 1) == 0);
                    d0[u] = W'($urandom);
                end else if (!v0[u] && $urandom_range(0, 2) == 0) begin
                    v0[u] = 1'b1;
                    d0[u] = W'($urandom);
                end
                if (g1[u]) begin
                    v1[u] = ($urandom_range(0, 1) == 0);
                    d1[u] = W'($urandom);
                end else if (!v1[u] && $urandom_range(0, 2) == 0) begin
                    v1[u] = 1'b1;
                    d1[u] = W'($urandom);
                end
            end
            sampleCycle();
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obsVec(u) !== expV[u]) begin
                    errors++;
                    $display("[TB] FAIL random_model u=%0d cyc=%0d got=%b exp=%b", u, cyc, obsVec(u), expV[u]);
                end
            end
            finishCycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        v0 = 2'b00;
        v1 = 2'b00;
        for (int u = 0; u < 2; u++) begin
            d0[u]     = '0;
            d1[u]     = '0;
            frameT[u] = -1000;
            frameD[u] = '0;
            ownerM[u] = 1'b0;
            freeAt[u] = 0;
            lastG[u]  = 1'b1;
            g0[u]     = 1'b0;
            g1[u]     = 1'b0;
            expV[u]   = '0;
        end
        test_reset();
        test_single();
        test_tie_alternate();
        test_gap();
        test_reset_midframe();
        test_late();
        test_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_tx_sched.md
# piso_tx_sched

Two-requester transmit scheduler that owns one parallel-in/serial-out shift register. It arbitrates round-robin between two word sources with valid/ready handshakes, loads the winning word, and shifts it out LSB-first with a frame-valid qualifier. An optional idle gap separates frames. It sits between the parallel producers and the single serial output lane.

## Interface
- WIDTH, 8, bits per word; legal range 2..32
- GAP, 0, idle cycles inserted after each frame; legal range 0..15
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- req0_valid  input  1  requester 0 holds a word
- req0_data  input  WIDTH  requester 0 word
- req0_ready  output  1  requester 0 word accepted this cycle
- req1_valid  input  1  requester 1 holds a word
- req1_data  input  WIDTH  requester 1 word
- req1_ready  output  1  requester 1 word accepted this cycle
- sdout  output  1  serial data, LSB first
- sframe  output  1  sdout carries a valid bit
- sowner  output  1  requester index of the frame in flight
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse with the last bit of a frame

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: arbitrate among asserted valids. Exactly one valid → grant it. Both valid → grant the requester not granted last (round-robin pointer). The granted requester's ready is high combinationally in this cycle and the transfer occurs. The shift register loads the granted data. The bit counter clears, sowner takes the granted index, the pointer updates, and the state moves to SHIFT.
- At most one ready is high in any cycle. Ready is never high outside IDLE or while reset is high.
- SHIFT: sdout = shreg[0] and sframe = 1. Each cycle, shreg shifts right with zero fill and the counter increments. On count WIDTH-1, done = 1. The next state is GAP if GAP > 0, otherwise IDLE.
- GAP: sframe = 0 and sdout = 0. Count GAP cycles, then return to IDLE.
- Requesters hold valid and data stable until ready. The block samples data only on transfer cycles. A valid that drops before ready is simply not granted.
- The pointer resets to "1 last granted", so requester 0 wins the first tie.

## Timing
- Reset values: sdout 0, sframe 0, sowner 0, busy 0, done 0, both ready 0, state IDLE, shreg 0, counter 0.
- Transfer at cycle T:
  - Bit 0 appears on sdout at T+1, bit k at T+1+k.
  - sframe is high from T+1 to T+WIDTH inclusive.
  - done is high at T+WIDTH.
- Earliest next transfer is T+WIDTH+1+GAP. With GAP=0, one IDLE cycle separates frames (the transfer cycle itself has sframe=0).
- busy is high from T+1 through the last GAP cycle.
- sowner is stable for the whole frame and updates only on transfer.
- Reset asserted mid-frame aborts the frame. All outputs take reset values on the following edge, no done pulse is issued, and the pointer resets.
- A valid arriving during SHIFT or GAP waits, with ready low, until IDLE.

## Test plan
- Single word, WIDTH=8, GAP=0: req0_valid with data 0xA5 at cycle 2 → req0_ready at 2; sdout 1,0,1,0,0,1,0,1 on cycles 3–10; sframe high on 3–10; done at 10; sowner 0.
- Tie then alternate: both valids held continuously with data 0x0F (req0) and 0xF0 (req1) → grants in order 0,1,0,1. Ready pulses are 9 cycles apart and never overlap.
- GAP=3: two back-to-back req1 words → second ready arrives exactly WIDTH+1+3 cycles after the first; sframe stays low through the 3 gap cycles plus the IDLE cycle.
- Reset at the 4th bit of a frame → next cycle sframe=0, busy=0, no done. The first subsequent tie grants req0.
- Late request: req0 asserts valid during req1's SHIFT → req0_ready stays 0 until IDLE, then is granted. Its data must match the value held at the transfer cycle.
- Idle: no valids for 20 cycles → sframe, busy, done, and both readys stay 0.
